seq_datapath: RTL and testbench
===============================

SEQ_DATAPATH -- requirements
Module: seq_datapath

Interface
REQ-001 Parameter W, 16, datapath and register width (W >= 9).
REQ-002 Parameter NREG, 8, register count (power of 2, >= 2); RA = clog2(NREG).
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port start  in  1  instruction request; sampled only in IDLE.
REQ-006 Port op  in  3  opcode: 000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 11x illegal.
REQ-007 Port rd, rn, rm  in  RA each  destination, first source, shifted source.
REQ-008 Port shift  in  2  00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
REQ-009 Port imm8  in  8  immediate for MOVI.
REQ-010 Port busy  out  1  high in every non-IDLE state.
REQ-011 Port done  out  1  registered one-cycle completion pulse.
REQ-012 Port err  out  1  registered one-cycle pulse, coincident with done, for illegal op.
REQ-013 Port Z_out  out  3  status register: [0] zero, [1] negative, [2] signed overflow.
REQ-014 Port datapath_out  out  W  result register C.

Function
REQ-015 SHALL capture op, rd, rn, rm, shift, imm8 on the edge accepting start; later input changes SHALL have no effect on that instruction.
REQ-016 FSM states: IDLE, LOADA, LOADB, EXEC, WB; one transition per edge.
REQ-017 Paths: MOVI IDLE->WB; MOV, MVN IDLE->LOADB->EXEC->WB; ADD, AND IDLE->LOADA->LOADB->EXEC->WB; CMP IDLE->LOADA->LOADB->EXEC; illegal IDLE->IDLE with done and err pulsed, no other state change.
REQ-018 All paths SHALL return to IDLE from their final state.
REQ-019 LOADA SHALL load A with R[rn]; LOADB SHALL load B with R[rm].
REQ-020 EXEC SHALL load C with ALU result: ADD A+sh(B), CMP A-sh(B), AND A&sh(B), MOV 0+sh(B), MVN ~sh(B); arithmetic modulo 2^W.
REQ-021 EXEC SHALL load Z_out for ADD, CMP, AND, MVN (Z = result==0, N = result[W-1], V = signed overflow for ADD/CMP else 0); MOV and MOVI SHALL NOT alter Z_out.
REQ-022 WB SHALL write R[rd] with C for MOV/ADD/AND/MVN, or with sign-extended imm8 for MOVI (C unchanged by MOVI).
REQ-023 done SHALL be high exactly the cycle after the final commit edge; busy SHALL be low that cycle.
REQ-024 Latency start-edge to done-high: MOVI 2 cycles, MOV/MVN/CMP 4, ADD/AND 5, illegal 1.
REQ-025 start while busy SHALL be ignored and not queued; start in a done cycle SHALL be accepted (back-to-back).
REQ-026 rd equal to rn or rm SHALL be legal; sources are read before write.
REQ-027 Register file: one synchronous write port, combinational read; no write outside WB.

Reset
REQ-028 reset SHALL immediately force IDLE; A, B, C, Z_out, all registers, busy, done, err SHALL be 0.
REQ-029 reset mid-instruction SHALL abort it with no register write, no status update, no done.
REQ-030 First start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-031 Shared package seq_datapath_pkg SHALL hold the opcode enum, state enum, shift codes, ALU-op codes and status bit indices.
REQ-032 Register file SHALL be a sub-module regfile_p parametrised by W and NREG; shifter and ALU remain inline.

Verification
REQ-033 MOVI rd=0 imm8=0xFE -> done after 2 cycles, R0=0xFFFE, Z_out unchanged 000.
REQ-034 MOV rd=1 rm=0 shift=LSR1 -> done after 4 cycles, R1=0x7FFF, datapath_out=0x7FFF.
REQ-035 ADD rd=2 rn=1 rm=0 shift=00 -> done after 5 cycles, R2=0x7FFD, Z_out=000.
REQ-036 CMP rn=1 rm=0 -> done after 4 cycles, datapath_out=0x8001, Z_out=110, no register changed.
REQ-037 start op=110 -> done and err high 1 cycle later, no state change; start pulsed while busy ignored.
REQ-038 ADD in flight, reset asserted in EXEC -> all outputs 0 immediately, destination register 0, no done.

Source files
------------

// File: rtl/seq_datapath_pkg.sv
// Shared types and codes for the sequenced register/ALU datapath.
package seq_datapath_pkg;

  typedef enum logic [2:0] {
    OP_MOVI = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_CMP  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVN  = 3'b101
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADA,
    ST_LOADB,
    ST_EXEC,
    ST_WB
  } state_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_PASS,
    ALU_NOT
  } alu_op_e;

  // Bit positions inside the status register.
  localparam int unsigned STAT_Z = 0;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_V = 2;

  function automatic alu_op_e alu_op_of(logic [2:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_CMP:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_MVN:  return ALU_NOT;
      default: return ALU_PASS;
    endcase
  endfunction

  // MOV and MOVI leave the status register alone.
  function automatic logic sets_flags(logic [2:0] op);
    return (op == OP_ADD) || (op == OP_CMP) || (op == OP_AND) || (op == OP_MVN);
  endfunction

endpackage

// File: rtl/seq_datapath_regfile.sv
// Register file: one synchronous write port, two combinational read ports.
module regfile_p
  import seq_datapath_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int RA  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [RA-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [RA-1:0] raddr_a,
  input  logic [RA-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] mem_q [NREG];
  logic [W-1:0] mem_d [NREG];

  // Next register contents: single addressed write when enabled.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Register storage, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/seq_datapath.sv
// Multi-cycle datapath: instruction capture, A/B operand registers,
// inline shifter + ALU, result register C, status flags, register file.
//
// state   | meaning
// IDLE    | waiting for start; illegal ops complete here with err
// LOADA   | A <= R[rn]
// LOADB   | B <= R[rm]
// EXEC    | C <= ALU result, status update (CMP completes here)
// WB      | R[rd] <= C, or sign-extended imm8 for MOVI
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int RA  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [RA-1:0] rd,
  input  logic [RA-1:0] rn,
  input  logic [RA-1:0] rm,
  input  logic [1:0]    shift,
  input  logic [7:0]    imm8,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    Z_out,
  output logic [W-1:0]  datapath_out
);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [RA-1:0] rd_q, rd_d;
  logic [RA-1:0] rn_q, rn_d;
  logic [RA-1:0] rm_q, rm_d;
  logic [1:0]    shift_q, shift_d;
  logic [7:0]    imm8_q, imm8_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  c_q, c_d;
  logic [2:0]    status_q, status_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          rf_we;
  logic [W-1:0]  rf_wdata;
  logic [W-1:0]  rf_rdata_a;
  logic [W-1:0]  rf_rdata_b;
  logic [W-1:0]  sh_b;
  logic [W-1:0]  alu_res;
  logic          alu_v;

  regfile_p #(.W(W), .NREG(NREG)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (rf_wdata),
    .raddr_a (rn_q),
    .raddr_b (rm_q),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b)
  );

  // Barrel of one: optional single-bit shift of the B operand.
  always_comb begin
    sh_b = b_q;
    case (shift_q)
      SH_LSL1: sh_b = {b_q[W-2:0], 1'b0};
      SH_LSR1: sh_b = {1'b0, b_q[W-1:1]};
      SH_ASR1: sh_b = {b_q[W-1], b_q[W-1:1]};
      default: sh_b = b_q;
    endcase
  end

  // ALU; overflow only meaningful for add/subtract.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op_of(op_q))
      ALU_ADD: begin
        alu_res = a_q + sh_b;
        alu_v   = (a_q[W-1] == sh_b[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      ALU_SUB: begin
        alu_res = a_q - sh_b;
        alu_v   = (a_q[W-1] != sh_b[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      ALU_AND:  alu_res = a_q & sh_b;
      ALU_PASS: alu_res = sh_b;
      ALU_NOT:  alu_res = ~sh_b;
      default:  alu_res = '0;
    endcase
  end

  // Sequencer: next state, register loads and completion pulses.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    shift_d  = shift_q;
    imm8_d   = imm8_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    status_d = status_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = c_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          rd_d    = rd;
          rn_d    = rn;
          rm_d    = rm;
          shift_d = shift;
          imm8_d  = imm8;
          case (op)
            OP_MOVI:               state_d = ST_WB;
            OP_MOV, OP_MVN:        state_d = ST_LOADB;
            OP_ADD, OP_AND, OP_CMP: state_d = ST_LOADA;
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      ST_LOADA: begin
        a_d     = rf_rdata_a;
        state_d = ST_LOADB;
      end
      ST_LOADB: begin
        b_d     = rf_rdata_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        c_d = alu_res;
        if (sets_flags(op_q)) begin
          status_d[STAT_Z] = (alu_res == '0);
          status_d[STAT_N] = alu_res[W-1];
          status_d[STAT_V] = alu_v;
        end
        if (op_q == OP_CMP) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        rf_we    = 1'b1;
        rf_wdata = (op_q == OP_MOVI) ? {{(W-8){imm8_q[7]}}, imm8_q} : c_q;
        state_d  = ST_IDLE;
        done_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shift_q  <= '0;
      imm8_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      shift_q  <= shift_d;
      imm8_q   <= imm8_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign Z_out        = status_q;
  assign datapath_out = c_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath against an arithmetic reference model.
module tb_seq_datapath;

  localparam int W    = 16;
  localparam int NREG = 8;
  localparam int M    = 65536;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  rd, rn, rm;
  logic [1:0]  shift;
  logic [7:0]  imm8;
  logic        busy, done, err;
  logic [2:0]  Z_out;
  logic [W-1:0] datapath_out;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int       m_reg [NREG];
  int       m_c;
  logic [2:0] m_z;

  seq_datapath #(.W(W), .NREG(NREG)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .rd           (rd),
    .rn           (rn),
    .rm           (rm),
    .shift        (shift),
    .imm8         (imm8),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .Z_out        (Z_out),
    .datapath_out (datapath_out)
  );

  always #5 clk = ~clk;

  function automatic int sgn(int x);
    return (x >= M/2) ? x - M : x;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NREG; k++) m_reg[k] = 0;
    m_c = 0;
    m_z = 3'b000;
  endtask

  // Instruction semantics computed with plain integer arithmetic.
  task automatic model_step(input int o, input int d, input int n, input int m,
                            input int s, input int i, output int lat, output bit e);
    int a, b, x, res, full;
    bit fl, v;
    a = m_reg[n]; b = m_reg[m];
    e = 0; fl = 0; v = 0; res = 0; full = 0; lat = 1;
    case (s)
      0: x = b;
      1: x = (b * 2) % M;
      2: x = b / 2;
      default: x = b / 2 + ((b >= M/2) ? M/2 : 0);
    endcase
    case (o)
      0: begin lat = 2; m_reg[d] = (i >= 128) ? i + M - 256 : i; end
      1: begin lat = 4; m_c = x; m_reg[d] = x; end
      2: begin lat = 5; res = (a + x) % M; full = sgn(a) + sgn(x); fl = 1;
               v = (full > M/2 - 1) || (full < -M/2); m_c = res; m_reg[d] = res; end
      3: begin lat = 4; res = (a - x + M) % M; full = sgn(a) - sgn(x); fl = 1;
               v = (full > M/2 - 1) || (full < -M/2); m_c = res; end
      4: begin lat = 5; res = a & x; fl = 1; m_c = res; m_reg[d] = res; end
      5: begin lat = 4; res = M - 1 - x; fl = 1; m_c = res; m_reg[d] = res; end
      default: begin lat = 1; e = 1; end
    endcase
    if (fl) m_z = {v, (res >= M/2), (res == 0)};
  endtask

  // Drive one instruction from a negedge; return at the negedge where done is seen.
  task automatic issue(input int o, input int d, input int n, input int m, input int s,
                       input int i, input bit poke,
                       output int lat, output bit e, output bit bz, output bit stray);
    op = 3'(o); rd = 3'(d); rn = 3'(n); rm = 3'(m); shift = 2'(s); imm8 = 8'(i);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = poke;
    op = 3'($urandom_range(0, 7)); rd = 3'($urandom_range(0, 7));
    rn = 3'($urandom_range(0, 7)); rm = 3'($urandom_range(0, 7));
    shift = 2'($urandom_range(0, 3)); imm8 = 8'($urandom_range(0, 255));
    lat = 0; stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (err || !busy) stray = 1;
      if (poke) begin
        op = 3'($urandom_range(0, 5)); rd = 3'($urandom_range(0, 7));
        imm8 = 8'($urandom_range(0, 255));
      end
    end
    start = 1'b0;
    e  = err;
    bz = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op = '0; rd = '0; rn = '0; rm = '0; shift = '0; imm8 = '0;
    model_clear();
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (Z_out !== 3'b000) begin miscompares++; $display("FAIL reset_z got %b want 000", Z_out); end
    vectors++; if (datapath_out !== '0) begin miscompares++; $display("FAIL reset_c got %h want 0", datapath_out); end
    for (int k = 0; k < NREG; k++) begin
      vectors++;
      if (dut.u_rf.mem_q[k] !== '0) begin
        miscompares++; $display("FAIL reset_reg%0d got %h want 0", k, dut.u_rf.mem_q[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int lat, elat; bit e, ee, bz, st;
    // MOVI R0, 0xFE
    model_step(0, 0, 0, 0, 0, 8'hFE, elat, ee);
    issue(0, 0, 0, 0, 0, 8'hFE, 0, lat, e, bz, st);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL movi_lat got %0d want 2", lat); end
    vectors++; if (dut.u_rf.mem_q[0] !== 16'hFFFE) begin miscompares++; $display("FAIL movi_r0 got %h want fffe", dut.u_rf.mem_q[0]); end
    vectors++; if (Z_out !== 3'b000) begin miscompares++; $display("FAIL movi_z got %b want 000", Z_out); end
    vectors++; if (bz !== 1'b0 || st) begin miscompares++; $display("FAIL movi_busy got busy=%b stray=%b want 0/0", bz, st); end
    // MOV R1, R0 LSR1
    model_step(1, 1, 0, 0, 2, 0, elat, ee);
    issue(1, 1, 0, 0, 2, 0, 0, lat, e, bz, st);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL mov_lat got %0d want 4", lat); end
    vectors++; if (dut.u_rf.mem_q[1] !== 16'h7FFF) begin miscompares++; $display("FAIL mov_r1 got %h want 7fff", dut.u_rf.mem_q[1]); end
    vectors++; if (datapath_out !== 16'h7FFF) begin miscompares++; $display("FAIL mov_c got %h want 7fff", datapath_out); end
    // ADD R2, R1, R0
    model_step(2, 2, 1, 0, 0, 0, elat, ee);
    issue(2, 2, 1, 0, 0, 0, 0, lat, e, bz, st);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL add_lat got %0d want 5", lat); end
    vectors++; if (dut.u_rf.mem_q[2] !== 16'h7FFD) begin miscompares++; $display("FAIL add_r2 got %h want 7ffd", dut.u_rf.mem_q[2]); end
    vectors++; if (Z_out !== 3'b000) begin miscompares++; $display("FAIL add_z got %b want 000", Z_out); end
    // CMP R1, R0 (rd=3 must stay untouched)
    model_step(3, 3, 1, 0, 0, 0, elat, ee);
    issue(3, 3, 1, 0, 0, 0, 0, lat, e, bz, st);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL cmp_lat got %0d want 4", lat); end
    vectors++; if (datapath_out !== 16'h8001) begin miscompares++; $display("FAIL cmp_c got %h want 8001", datapath_out); end
    vectors++; if (Z_out !== 3'b110) begin miscompares++; $display("FAIL cmp_z got %b want 110", Z_out); end
    vectors++; if (dut.u_rf.mem_q[3] !== 16'h0000) begin miscompares++; $display("FAIL cmp_r3 got %h want 0", dut.u_rf.mem_q[3]); end
  endtask

  task automatic test_illegal();
    int lat, elat; bit e, ee, bz, st;
    for (int o = 6; o < 8; o++) begin
      model_step(o, 4, 1, 0, 1, 8'h55, elat, ee);
      issue(o, 4, 1, 0, 1, 8'h55, 0, lat, e, bz, st);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL illegal%0d_lat got %0d want 1", o, lat); end
      vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL illegal%0d_err got %b want 1", o, e); end
      vectors++; if (bz !== 1'b0) begin miscompares++; $display("FAIL illegal%0d_busy got %b want 0", o, bz); end
      vectors++; if (Z_out !== m_z) begin miscompares++; $display("FAIL illegal%0d_z got %b want %b", o, Z_out, m_z); end
      vectors++; if (datapath_out !== 16'(m_c)) begin miscompares++; $display("FAIL illegal%0d_c got %h want %h", o, datapath_out, 16'(m_c)); end
      for (int k = 0; k < NREG; k++) begin
        vectors++;
        if (dut.u_rf.mem_q[k] !== 16'(m_reg[k])) begin
          miscompares++; $display("FAIL illegal%0d_reg%0d got %h want %h", o, k, dut.u_rf.mem_q[k], 16'(m_reg[k]));
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, elat; bit e, ee, bz, st;
    model_step(2, 5, 2, 1, 3, 0, elat, ee);
    issue(2, 5, 2, 1, 3, 0, 1, lat, e, bz, st);
    vectors++; if (lat !== elat) begin miscompares++; $display("FAIL busy_lat got %0d want %0d", lat, elat); end
    vectors++; if (st) begin miscompares++; $display("FAIL busy_stray got 1 want 0"); end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL busy_queued got done=%b busy=%b want 0/0", done, busy);
      end
    end
    for (int k = 0; k < NREG; k++) begin
      vectors++;
      if (dut.u_rf.mem_q[k] !== 16'(m_reg[k])) begin
        miscompares++; $display("FAIL busy_reg%0d got %h want %h", k, dut.u_rf.mem_q[k], 16'(m_reg[k]));
      end
    end
  endtask

  task automatic test_random(input int n, input bit gaps);
    int lat, elat, o, d, rn_i, rm_i, s, im, r, g; bit e, ee, bz, st, pk;
    for (int t = 0; t < n; t++) begin
      r = $urandom_range(0, 15);
      o = (r < 14) ? r % 6 : 6 + (r - 14);
      d = $urandom_range(0, 7); rn_i = $urandom_range(0, 7); rm_i = $urandom_range(0, 7);
      s = $urandom_range(0, 3); im = $urandom_range(0, 255);
      pk = gaps && (o < 6) && ($urandom_range(0, 3) == 0);
      model_step(o, d, rn_i, rm_i, s, im, elat, ee);
      issue(o, d, rn_i, rm_i, s, im, pk, lat, e, bz, st);
      vectors++; if (lat !== elat) begin miscompares++; $display("FAIL rnd%0d_lat op=%0d got %0d want %0d", t, o, lat, elat); end
      vectors++; if (e !== ee) begin miscompares++; $display("FAIL rnd%0d_err op=%0d got %b want %b", t, o, e, ee); end
      vectors++; if (bz !== 1'b0 || st) begin miscompares++; $display("FAIL rnd%0d_busy got busy=%b stray=%b want 0/0", t, bz, st); end
      vectors++; if (datapath_out !== 16'(m_c)) begin miscompares++; $display("FAIL rnd%0d_c op=%0d got %h want %h", t, o, datapath_out, 16'(m_c)); end
      vectors++; if (Z_out !== m_z) begin miscompares++; $display("FAIL rnd%0d_z op=%0d got %b want %b", t, o, Z_out, m_z); end
      for (int k = 0; k < NREG; k++) begin
        vectors++;
        if (dut.u_rf.mem_q[k] !== 16'(m_reg[k])) begin
          miscompares++; $display("FAIL rnd%0d_reg%0d op=%0d got %h want %h", t, k, o, dut.u_rf.mem_q[k], 16'(m_reg[k]));
        end
      end
      if (gaps) begin
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          @(negedge clk);
          vectors++;
          if (done !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_done_width got %b want 0", t, done); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_random(25, 1'b0);
  endtask

  task automatic test_reset_mid();
    int lat, elat; bit e, ee, bz, st;
    op = 3'b010; rd = 3'd6; rn = 3'd2; rm = 3'd1; shift = 2'b00; imm8 = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_clear();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b want 0", done); end
    vectors++; if (Z_out !== 3'b000) begin miscompares++; $display("FAIL rstmid_z got %b want 000", Z_out); end
    vectors++; if (datapath_out !== '0) begin miscompares++; $display("FAIL rstmid_c got %h want 0", datapath_out); end
    for (int k = 0; k < NREG; k++) begin
      vectors++;
      if (dut.u_rf.mem_q[k] !== '0) begin
        miscompares++; $display("FAIL rstmid_reg%0d got %h want 0", k, dut.u_rf.mem_q[k]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_nodone got %b want 0", done); end
    reset = 1'b0;
    // first start right after deassert
    model_step(0, 7, 0, 0, 0, 8'h80, elat, ee);
    issue(0, 7, 0, 0, 0, 8'h80, 0, lat, e, bz, st);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL postrst_lat got %0d want 2", lat); end
    vectors++; if (dut.u_rf.mem_q[7] !== 16'hFF80) begin miscompares++; $display("FAIL postrst_r7 got %h want ff80", dut.u_rf.mem_q[7]); end
    vectors++; if (dut.u_rf.mem_q[6] !== 16'h0000) begin miscompares++; $display("FAIL postrst_r6 got %h want 0", dut.u_rf.mem_q[6]); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_busy_ignore();
    test_back_to_back();
    test_random(150, 1'b1);
    test_reset_mid();
    test_random(30, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
